// File: rtl/mem_bus_pkg.sv
// Shared definitions for the 32-bit CPU to 16-bit memory bus bridge:
// size encodings, bridge FSM states and bus widths.
package mem_bus_pkg;

  localparam int CPU_W = 32;
  localparam int MEM_W = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

  // Size 11 is never legal, so it is folded into the misaligned case.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = a[0];
      SZ_WORD: is_misaligned = |a;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/halfword_bus_bridge_if.sv
// CPU load/store port and 16-bit data-memory bus, each with master/slave views.
interface cpu_req_if;
  import mem_bus_pkg::*;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [CPU_W-1:0] req_addr;
  logic [CPU_W-1:0] req_wdata;
  logic             resp_valid;
  logic             resp_err;
  logic [CPU_W-1:0] resp_rdata;

  modport master (output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_err, resp_rdata);
  modport slave  (input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_err, resp_rdata);
endinterface

interface mem_bus_if;
  import mem_bus_pkg::*;
  logic             mem_valid;
  logic             mem_ready;
  logic             mem_we;
  logic [CPU_W-1:0] mem_addr;
  logic [MEM_W-1:0] mem_wdata;
  logic [1:0]       mem_be;
  logic [MEM_W-1:0] mem_rdata;

  modport master (output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/load_extend.sv
// Selects the byte/half from a 16-bit read beat and sign- or zero-extends it to 32 bits.
module load_extend
  import mem_bus_pkg::*;
(
  input  logic [MEM_W-1:0] beat_i,
  input  logic             addr0_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  output logic [CPU_W-1:0] data_o
);

  logic [7:0] byte_sel;
  logic       fill;

  always_comb begin
    byte_sel = addr0_i ? beat_i[15:8] : beat_i[7:0];
    if (size_i == SZ_BYTE) begin
      fill   = ~unsigned_i & byte_sel[7];
      data_o = {{24{fill}}, byte_sel};
    end else begin
      fill   = ~unsigned_i & beat_i[15];
      data_o = {{16{fill}}, beat_i};
    end
  end

endmodule

// File: rtl/halfword_bus_bridge.sv
// Splits CPU loads/stores into one or two 16-bit memory beats and reassembles
// load data; one request in flight, all outputs except req_ready registered.
module halfword_bus_bridge
  import mem_bus_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  cpu_req_if.slave  cpu,
  mem_bus_if.master mem
);

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic             addr0_q, addr0_d;
  logic [MEM_W-1:0] wdata_hi_q, wdata_hi_d;
  logic [MEM_W-1:0] lo_q, lo_d;

  logic             mem_valid_q, mem_valid_d;
  logic             mem_we_q, mem_we_d;
  logic [CPU_W-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]       mem_be_q, mem_be_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [CPU_W-1:0] resp_rdata_q, resp_rdata_d;

  logic [CPU_W-1:0] ext;

  load_extend u_ext (
    .beat_i     (mem.mem_rdata),
    .addr0_i    (addr0_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext)
  );

  assign cpu.req_ready  = (state_q == IDLE) && !rst;
  assign cpu.resp_valid = resp_valid_q;
  assign cpu.resp_err   = resp_err_q;
  assign cpu.resp_rdata = resp_rdata_q;
  assign mem.mem_valid  = mem_valid_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wdata  = mem_wdata_q;
  assign mem.mem_be     = mem_be_q;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr0_d      = addr0_q;
    wdata_hi_d   = wdata_hi_q;
    lo_d         = lo_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      IDLE: if (cpu.req_valid) begin
        we_d       = cpu.req_we;
        size_d     = cpu.req_size;
        uns_d      = cpu.req_unsigned;
        addr0_d    = cpu.req_addr[0];
        wdata_hi_d = cpu.req_wdata[31:16];
        if (is_misaligned(cpu.req_size, cpu.req_addr[1:0])) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          state_d     = BEAT0;
          mem_valid_d = 1'b1;
          mem_we_d    = cpu.req_we;
          mem_addr_d  = {cpu.req_addr[31:1], 1'b0};
          // Byte stores replicate into both lanes; the enable picks the live one.
          if (cpu.req_size == SZ_BYTE) begin
            mem_wdata_d = {2{cpu.req_wdata[7:0]}};
            mem_be_d    = cpu.req_addr[0] ? 2'b10 : 2'b01;
          end else begin
            mem_wdata_d = cpu.req_wdata[15:0];
            mem_be_d    = 2'b11;
          end
        end
      end
      BEAT0: if (mem.mem_ready) begin
        if (size_q == SZ_WORD) begin
          state_d     = BEAT1;
          mem_addr_d  = mem_addr_q + 32'd2;
          mem_wdata_d = wdata_hi_q;
          lo_d        = mem.mem_rdata;
        end else begin
          state_d      = RESP;
          mem_valid_d  = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? '0 : ext;
        end
      end
      BEAT1: if (mem.mem_ready) begin
        state_d      = RESP;
        mem_valid_d  = 1'b0;
        resp_valid_d = 1'b1;
        resp_rdata_d = we_q ? '0 : {mem.mem_rdata, lo_q};
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      addr0_q      <= 1'b0;
      wdata_hi_q   <= '0;
      lo_q         <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr0_q      <= addr0_d;
      wdata_hi_q   <= wdata_hi_d;
      lo_q         <= lo_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_halfword_bus_bridge.sv
// Scoreboard bench: expected beats and responses are queued at issue time;
// a memory responder and a response monitor pop and compare independently.
module tb_halfword_bus_bridge;
  import mem_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_req_if cpu ();
  mem_bus_if mem ();

  halfword_bus_bridge dut (.clk(clk), .rst(rst), .cpu(cpu), .mem(mem));

  typedef struct {logic err; logic [31:0] rdata; int lat; int t;} resp_t;
  typedef struct {logic we; logic [31:0] addr; logic [15:0] wdata; logic [1:0] be;
                  logic [15:0] rdata; int stall;} beat_t;

  resp_t exp_q[$];
  beat_t beat_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, resp_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    resp_t e;
    if (!rst && cpu.resp_valid) begin
      resp_seen++;
      if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("resp_err", {31'd0, cpu.resp_err}, {31'd0, e.err});
        chk("resp_rdata", cpu.resp_rdata, e.rdata);
        chk("resp_latency", 32'(cyc - e.t), 32'(e.lat));
      end
    end
  end

  // Memory responder: checks each beat on first sight, stability while stalled
  beat_t cur;
  bit    have = 0;
  int    stall_left = 0;
  logic [31:0] s_addr;
  logic [18:0] s_ctl;

  always @(negedge clk) begin
    if (rst) begin
      mem.mem_ready = 1'b0;
      mem.mem_rdata = 16'h0;
      have = 0;
    end else if (mem.mem_valid) begin
      if (!have) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
          cur.rdata = 16'h0;
          cur.stall = 0;
        end else begin
          cur = beat_q.pop_front();
          chk("beat_addr", mem.mem_addr, cur.addr);
          chk("beat_we", {31'd0, mem.mem_we}, {31'd0, cur.we});
          chk("beat_be", {30'd0, mem.mem_be}, {30'd0, cur.be});
          if (cur.we) chk("beat_wdata", {16'd0, mem.mem_wdata}, {16'd0, cur.wdata});
        end
        have = 1;
        stall_left = cur.stall;
        s_addr = mem.mem_addr;
        s_ctl = {mem.mem_we, mem.mem_be, mem.mem_wdata};
      end else begin
        chk("stall_addr_stable", mem.mem_addr, s_addr);
        chk("stall_ctl_stable", {13'd0, mem.mem_we, mem.mem_be, mem.mem_wdata}, {13'd0, s_ctl});
      end
      if (stall_left > 0) begin
        mem.mem_ready = 1'b0;
        stall_left--;
      end else begin
        mem.mem_ready = 1'b1;
        mem.mem_rdata = cur.rdata;
        have = 0;
      end
    end else begin
      if (have) chk("mem_valid_dropped", 32'd0, 32'd1);
      have = 0;
      mem.mem_ready = 1'b0;
    end
  end

  task automatic add_beat(input logic we, input logic [31:0] a, input logic [15:0] wd,
                          input logic [1:0] be, input logic [15:0] rd, input int stall);
    beat_t b;
    b.we = we; b.addr = a; b.wdata = wd; b.be = be; b.rdata = rd; b.stall = stall;
    beat_q.push_back(b);
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic err, input logic [31:0] rd, input int lat);
    resp_t e;
    bit ok = 0;
    @(posedge clk); #1;
    cpu.req_we = we; cpu.req_size = sz; cpu.req_unsigned = uns;
    cpu.req_addr = a; cpu.req_wdata = wd; cpu.req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cpu.req_ready) ok = 1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      e.err = err; e.rdata = rd; e.lat = lat; e.t = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cpu.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    if (beat_q.size() != 0) begin
      chk("beats_left", 32'(beat_q.size()), 32'd0);
      beat_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    cpu.req_valid = 1'b0; cpu.req_we = 1'b0; cpu.req_size = SZ_BYTE;
    cpu.req_unsigned = 1'b0; cpu.req_addr = '0; cpu.req_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_req_ready", {31'd0, cpu.req_ready}, 32'd0);
    chk("rst_mem_ctl", {13'd0, mem.mem_valid, mem.mem_we, mem.mem_be, mem.mem_wdata}, 32'd0);
    chk("rst_mem_addr", mem.mem_addr, 32'd0);
    chk("rst_resp_ctl", {30'd0, cpu.resp_valid, cpu.resp_err}, 32'd0);
    chk("rst_resp_rdata", cpu.resp_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("ready_after_rst", {31'd0, cpu.req_ready}, 32'd1);

    // Loads: byte/half extension
    add_beat(0, 32'h1000, 16'h0, 2'b10, 16'h80FF, 0);
    issue(0, SZ_BYTE, 0, 32'h1001, 32'h0, 0, 32'hFFFFFF80, 2); drain();
    add_beat(0, 32'h1000, 16'h0, 2'b10, 16'h80FF, 0);
    issue(0, SZ_BYTE, 1, 32'h1001, 32'h0, 0, 32'h00000080, 2); drain();
    add_beat(0, 32'h1000, 16'h0, 2'b01, 16'h80FF, 0);
    issue(0, SZ_BYTE, 0, 32'h1000, 32'h0, 0, 32'hFFFFFFFF, 2); drain();
    add_beat(0, 32'h2000, 16'h0, 2'b11, 16'h8001, 0);
    issue(0, SZ_HALF, 0, 32'h2000, 32'h0, 0, 32'hFFFF8001, 2); drain();
    add_beat(0, 32'h2000, 16'h0, 2'b11, 16'h8001, 0);
    issue(0, SZ_HALF, 1, 32'h2000, 32'h0, 0, 32'h00008001, 2); drain();

    // Word load with a two-cycle stall on beat0
    add_beat(0, 32'h3000, 16'h0, 2'b11, 16'h5678, 2);
    add_beat(0, 32'h3002, 16'h0, 2'b11, 16'h1234, 0);
    issue(0, SZ_WORD, 0, 32'h3000, 32'h0, 0, 32'h12345678, 5); drain();

    // Stores
    add_beat(1, 32'h40, 16'hCCDD, 2'b11, 16'h0, 0);
    add_beat(1, 32'h42, 16'hAABB, 2'b11, 16'h0, 0);
    issue(1, SZ_WORD, 0, 32'h40, 32'hAABBCCDD, 0, 32'h0, 3); drain();
    add_beat(1, 32'h42, 16'hDDDD, 2'b10, 16'h0, 0);
    issue(1, SZ_BYTE, 0, 32'h43, 32'hAABBCCDD, 0, 32'h0, 2); drain();
    add_beat(1, 32'h10, 16'h5678, 2'b11, 16'h0, 1);
    issue(1, SZ_HALF, 0, 32'h10, 32'h12345678, 0, 32'h0, 3); drain();

    // Misaligned / illegal: no beats, immediate error
    issue(0, SZ_WORD, 0, 32'h0002, 32'h0, 1, 32'h0, 1); drain();
    issue(1, SZ_HALF, 0, 32'h0011, 32'hFFFF, 1, 32'h0, 1); drain();
    issue(0, 2'b11, 0, 32'h0100, 32'h0, 1, 32'h0, 1); drain();

    // Reset while beat1 is stalled
    add_beat(0, 32'h3000, 16'h0, 2'b11, 16'h1111, 0);
    add_beat(0, 32'h3002, 16'h0, 2'b11, 16'h2222, 1000);
    issue(0, SZ_WORD, 0, 32'h3000, 32'h0, 0, 32'h22221111, 3);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    seen = resp_seen;
    #1 chk("rst_drops_mem_valid", {31'd0, mem.mem_valid}, 32'd0);
    exp_q.delete();
    beat_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    chk("no_resp_after_rst", 32'(resp_seen), 32'(seen));
    add_beat(0, 32'h2000, 16'h0, 2'b11, 16'h7FFE, 0);
    issue(0, SZ_HALF, 0, 32'h2000, 32'h0, 0, 32'h00007FFE, 2); drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/halfword_bus_bridge.md
# halfword_bus_bridge

Bridges the CPU's 32-bit load/store port to the 16-bit data-memory bus. Stores are narrowed and split into one or two 16-bit beats; loads are reassembled from one or two beats, and byte/halfword results are sign- or zero-extended to 32 bits. It sits between the MEM stage and the data memory and completes one request at a time under a valid/ready handshake on both sides.

## Interface
- No parameters. Data widths are fixed at 32 bits on the CPU side and 16 bits on the memory side.
- `clk` in 1: the single clock; rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: the CPU request is valid.
- `req_ready` out 1: the bridge can accept a request. High only in IDLE with `rst` low.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal (treated as misaligned).
- `req_unsigned` in 1: zero-extend loads (lbu/lhu). Ignored for words and for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `resp_valid` out 1: one-cycle pulse marking completion.
- `resp_err` out 1: misaligned or illegal request. Qualified by `resp_valid`.
- `resp_rdata` out 32: load result. Zero for stores and errors.
- `mem_valid` out 1: a memory beat is requested.
- `mem_ready` in 1: the beat completes this cycle. For reads, `mem_rdata` is valid in the same cycle.
- `mem_we` out 1: write beat.
- `mem_addr` out 32: halfword-aligned address; bit 0 is always 0.
- `mem_wdata` out 16: write data.
- `mem_be` out 2: lane enables. Bit 0 = bits [7:0], bit 1 = bits [15:8].
- `mem_rdata` in 16: read data.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: a request is accepted when `req_valid` and `req_ready` are both high. The request is latched.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]≠0, or size 11): go to RESP with err=1. No memory beat is issued.
  - Otherwise go to BEAT0.
- BEAT0: `mem_valid`=1 and `mem_addr`={addr[31:1],1'b0}. On handshake:
  - word → BEAT1;
  - byte or half → RESP.
- BEAT1: `mem_addr` = beat0 address + 2. On handshake → RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then → IDLE.
- Store lanes (little-endian):
  - byte: wdata={wd[7:0],wd[7:0]}, be = addr[0] ? 10 : 01.
  - half: wd[15:0], be=11.
  - word: beat0 carries wd[15:0], beat1 carries wd[31:16], be=11 on both beats.
- Load lanes: `mem_be` is driven exactly as for stores.
  - byte: select rdata[15:8] if addr[0]=1, else rdata[7:0]; extend from bit 7.
  - half: extend from bit 15.
  - Extension is a zero fill when `req_unsigned`=1, otherwise a copy of the sign bit.
  - word: the beat0 data is latched as [15:0]; the beat1 data supplies [31:16].
- While `mem_valid`=1 and `mem_ready`=0, all `mem_*` outputs hold stable. `mem_valid` never drops before its handshake.
- `rst` asserted in any state: the FSM goes to IDLE immediately and `mem_valid` drops. The request in flight is discarded and no `resp_valid` is issued.

## Timing
- Reset values:
  - `mem_valid`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `resp_valid`, `resp_err`, `resp_rdata` are all 0.
  - `req_ready` is 0 while `rst` is high, and 1 in the first cycle after release.
- All outputs except `req_ready` are registered. `req_ready` is decoded from the state register.
- Latency with `mem_ready` tied high, request accepted in cycle T:
  - byte/half: beat in T+1, `resp_valid` in T+2.
  - word: beats in T+1 and T+2, `resp_valid` in T+3.
  - misaligned: `resp_valid` in T+1.
- Each cycle with `mem_ready`=0 adds one cycle of latency per beat.
- A request can be accepted no earlier than the cycle after RESP. Maximum rate is one half every 3 cycles.

## Structure
- Shared package `mem_bus_pkg` holds:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - the FSM state enum;
  - the bus width constants (32 and 16).
- Sub-module `load_extend` is combinational. Inputs: 16-bit beat, addr[0], size, unsigned. Output: the 32-bit extended value. It is instantiated once, for byte/half results.

## Test plan
- Byte loads, addr=0x1001, `mem_rdata`=0x80FF:
  - lb: `resp_rdata`=0xFFFFFF80 at T+2;
  - lbu: `resp_rdata`=0x00000080.
- lh, addr=0x2000, `mem_rdata`=0x8001 → `resp_rdata`=0xFFFF8001.
- lw, addr=0x3000, beats 0x5678 then 0x1234, `mem_ready` low for 2 cycles on beat0:
  - `mem_addr` goes 0x3000 then 0x3002;
  - `resp_rdata`=0x12345678 at T+5;
  - `mem_*` outputs stay stable during the stall.
- Stores of wdata=0xAABBCCDD:
  - sw at 0x40: beats (0x40, 0xCCDD, be 11) then (0x42, 0xAABB, be 11);
  - sb at 0x43: one beat (0x42, 0xDDDD, be 10).
- lw at 0x0002 → no `mem_valid`; `resp_valid` with `resp_err`=1 and `resp_rdata`=0 at T+1.
- `rst` asserted during a stalled BEAT1:
  - `mem_valid` drops immediately and no `resp_valid` ever appears;
  - after release, a new lh completes normally.
